// File: rtl/lv165_pkg.sv
// Shared types and constants for the 74LV165 daisy-chain scan controller.
package lv165_pkg;

  localparam int unsigned LV165_BITS         = 8;
  localparam int unsigned LV165_HALF_DEFAULT = 2;
  localparam int unsigned LV165_PHASE_W      = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_SETTLE   = 3'd2,
    ST_SHIFT_LO = 3'd3,
    ST_SHIFT_HI = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

  // States during which a scan is in flight and o_busy is asserted.
  function automatic logic is_busy_state(input state_e s);
    return (s == ST_LOAD) || (s == ST_SETTLE) || (s == ST_SHIFT_LO) || (s == ST_SHIFT_HI);
  endfunction

endpackage

// File: rtl/lv165_scan_ctrl_phase_timer.sv
// Loadable down-counter; o_expire pulses for one cycle in the last cycle of a phase.
module lv165_scan_ctrl_phase_timer
  import lv165_pkg::*;
(
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_load,
  input  logic [LV165_PHASE_W-1:0] i_load_val,
  output logic                     o_expire
);

  logic [LV165_PHASE_W-1:0] cnt_q, cnt_d;
  logic                     expire_q, expire_d;

  // Count from the load value down to zero and hold there; expire marks the zero cycle.
  always_comb begin
    cnt_d    = cnt_q;
    expire_d = 1'b0;
    if (i_load) begin
      cnt_d    = i_load_val;
      expire_d = (i_load_val == '0);
    end else if (cnt_q != '0) begin
      cnt_d    = cnt_q - LV165_PHASE_W'(1);
      expire_d = (cnt_q == LV165_PHASE_W'(1));
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q    <= '0;
      expire_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      expire_q <= expire_d;
    end
  end

  assign o_expire = expire_q;

endmodule

// File: rtl/lv165_scan_ctrl.sv
// Sequencer for a chain of 74LV165 shift registers: SH/LD pulse, serial clock,
// QH sampling and parallel word assembly with a one-cycle valid strobe.
module lv165_scan_ctrl
  import lv165_pkg::*;
#(
  parameter int unsigned NCHIPS = 1,
  parameter int unsigned WIDTH  = LV165_BITS * NCHIPS,
  parameter int unsigned HALF   = LV165_HALF_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_q,
  output logic             o_sh_ld_n,
  output logic             o_serclk,
  output logic             o_busy,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  localparam int unsigned BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [LV165_PHASE_W-1:0] PHASE_LAST = LV165_PHASE_W'(HALF - 1);
  localparam logic [BIT_W-1:0]         BIT_LAST   = BIT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [WIDTH-1:0]   sreg_q, sreg_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               sh_ld_n_q, sh_ld_n_d;
  logic               serclk_q, serclk_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;
  logic               timer_load_c;
  logic               phase_expire;

  // Every state lasts HALF cycles except IDLE and DONE; the timer restarts on each entry.
  lv165_scan_ctrl_phase_timer u_phase_timer (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (timer_load_c),
    .i_load_val (PHASE_LAST),
    .o_expire   (phase_expire)
  );

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    sreg_d  = sreg_q;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_LOAD;
          bit_d   = '0;
        end
      end
      ST_LOAD: begin
        if (phase_expire) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (phase_expire) state_d = ST_SHIFT_LO;
      end
      ST_SHIFT_LO: begin
        // Capture QH in the last low cycle, just ahead of the serclk rising edge.
        if (phase_expire) begin
          sreg_d  = WIDTH'({sreg_q, i_q});
          state_d = ST_SHIFT_HI;
        end
      end
      ST_SHIFT_HI: begin
        if (phase_expire) begin
          if (bit_q == BIT_LAST) begin
            state_d = ST_DONE;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            state_d = ST_SHIFT_LO;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    timer_load_c = (state_d != state_q);

    // Outputs are decoded from the next state so they line up with the state register.
    sh_ld_n_d = (state_d != ST_LOAD);
    serclk_d  = (state_d == ST_SHIFT_HI);
    busy_d    = is_busy_state(state_d);
    valid_d   = (state_d == ST_DONE);
    data_d    = valid_d ? sreg_q : data_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      bit_q     <= '0;
      sreg_q    <= '0;
      data_q    <= '1;
      sh_ld_n_q <= 1'b1;
      serclk_q  <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_q     <= bit_d;
      sreg_q    <= sreg_d;
      data_q    <= data_d;
      sh_ld_n_q <= sh_ld_n_d;
      serclk_q  <= serclk_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
    end
  end

  assign o_sh_ld_n = sh_ld_n_q;
  assign o_serclk  = serclk_q;
  assign o_busy    = busy_q;
  assign o_valid   = valid_q;
  assign o_data    = data_q;

endmodule

// File: tb/tb_lv165_scan_ctrl.sv
// Bench for lv165_scan_ctrl: four instances with different chain/HALF settings,
// each fed by a behavioural '165 chain; expectations come from the scan timing rules.
module tb_lv165_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start [4];
  logic        qmode [4];
  logic        qman  [4];
  logic [15:0] par   [4];
  wire         shld  [4];
  wire         sclk  [4];
  wire         busy  [4];
  wire         valid [4];
  wire  [15:0] dout  [4];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Instance configuration: 0 -> 1 chip HALF 2, 1 -> 2 chips HALF 1, 2 -> 1 chip HALF 1, 3 -> 1 chip HALF 3.
  function automatic int nc_of(input int g);
    return (g == 1) ? 2 : 1;
  endfunction

  function automatic int half_of(input int g);
    case (g)
      0:       return 2;
      1:       return 1;
      2:       return 1;
      default: return 3;
    endcase
  endfunction

  function automatic int lat_of(input int g);
    return 1 + half_of(g) * (2 + 2 * 8 * nc_of(g));
  endfunction

  function automatic logic [15:0] mask_of(input int g);
    return (nc_of(g) == 2) ? 16'hFFFF : 16'h00FF;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int NC = nc_of(g);
    localparam int W  = 8 * NC;
    localparam int H  = half_of(g);

    logic [W-1:0] chain;
    wire  [W-1:0] d;
    wire          qin;

    // Chain of '165s: async parallel load while SH/LD low, shift on serclk rise, QH = MSB.
    always @(posedge sclk[g] or negedge shld[g]) begin
      if (!shld[g]) chain <= par[g][W-1:0];
      else          chain <= {chain[W-2:0], 1'b0};
    end

    assign qin     = qmode[g] ? qman[g] : chain[W-1];
    assign dout[g] = 16'(d);

    lv165_scan_ctrl #(.NCHIPS(NC), .WIDTH(W), .HALF(H)) u_dut (
      .i_clk     (clk),
      .i_reset   (rst),
      .i_start   (start[g]),
      .i_q       (qin),
      .o_sh_ld_n (shld[g]),
      .o_serclk  (sclk[g]),
      .o_busy    (busy[g]),
      .o_valid   (valid[g]),
      .o_data    (d)
    );
  end

  // QH value presented in cycle j: the true bit only in cycle (sample cycle + off), its complement otherwise.
  function automatic logic qman_at(input int j, input int h, input int off, input logic [7:0] wv);
    int   k;
    int   s0;
    logic b;
    s0 = 3 * h + off;
    k  = (j < s0 - h) ? 0 : (j - s0 + h) / (2 * h);
    if (k > 7) k = 7;
    b = wv[7-k];
    return (j == 3 * h + 2 * h * k + off) ? b : !b;
  endfunction

  // Runs one scan on instance g and reports what was observed against the ideal waveform.
  // mode 0: plain; mode 1: extra start pulses and parallel-input change while busy; mode 2: QH driven by qman_at.
  task automatic do_scan(input int g, input logic [15:0] pv, input int mode, input int off,
                         output int vcyc, output logic [15:0] vdata, output int wave_err,
                         output int first_bad, output int rises, output int nvalid);
    int   h;
    int   lat;
    int   p;
    int   q;
    logic prev;
    logic e_shld, e_sclk, e_busy, e_valid;
    h = half_of(g);
    lat = lat_of(g);
    vcyc = -1; vdata = '0; wave_err = 0; first_bad = -1; rises = 0; nvalid = 0;
    par[g]   = pv;
    qmode[g] = (mode == 2);
    @(negedge clk);
    start[g] = 1'b1;
    if (mode == 2) qman[g] = qman_at(0, h, off, pv[7:0]);
    prev = sclk[g];
    for (int j = 1; j <= lat + 6; j++) begin
      @(negedge clk);
      if (mode == 1) begin
        start[g] = (j == 3 || j == 7 || j == 12 || j == 20 || j == lat - 2);
        if (j == h + 2) par[g] = ~pv;
      end else begin
        start[g] = 1'b0;
      end
      if (mode == 2) qman[g] = qman_at(j, h, off, pv[7:0]);
      if (j < lat) begin
        p = j - 1;
        q = p - 2 * h;
        e_shld = (p >= h);
        e_sclk = (p >= 2 * h) && ((q % (2 * h)) >= h);
        e_busy = 1'b1;
        e_valid = 1'b0;
      end else begin
        e_shld = 1'b1;
        e_sclk = 1'b0;
        e_busy = 1'b0;
        e_valid = (j == lat);
      end
      if (shld[g] !== e_shld || sclk[g] !== e_sclk || busy[g] !== e_busy || valid[g] !== e_valid) begin
        wave_err++;
        if (first_bad < 0) first_bad = j;
      end
      if (sclk[g] === 1'b1 && prev === 1'b0) rises++;
      prev = sclk[g];
      if (valid[g] === 1'b1) begin
        nvalid++;
        if (vcyc < 0) begin
          vcyc  = j;
          vdata = dout[g];
        end
      end
    end
    start[g] = 1'b0;
    qmode[g] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      total++; if (shld[g] !== 1'b1) begin bad++; $display("FAIL reset_shld dut%0d got=%b exp=1", g, shld[g]); end
      total++; if (sclk[g] !== 1'b0) begin bad++; $display("FAIL reset_serclk dut%0d got=%b exp=0", g, sclk[g]); end
      total++; if (busy[g] !== 1'b0) begin bad++; $display("FAIL reset_busy dut%0d got=%b exp=0", g, busy[g]); end
      total++; if (valid[g] !== 1'b0) begin bad++; $display("FAIL reset_valid dut%0d got=%b exp=0", g, valid[g]); end
      total++; if (dout[g] !== mask_of(g)) begin bad++; $display("FAIL reset_data dut%0d got=%h exp=%h", g, dout[g], mask_of(g)); end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [15:0] pv [3];
    int vc, we, fb, ri, nv;
    logic [15:0] vd;
    pv[0] = 16'h00A5;
    pv[1] = 16'($urandom) & 16'h00FF;
    pv[2] = 16'($urandom) & 16'h00FF;
    for (int i = 0; i < 3; i++) begin
      do_scan(0, pv[i], 0, 0, vc, vd, we, fb, ri, nv);
      total++; if (vc !== 37) begin bad++; $display("FAIL single_latency scan%0d got=%0d exp=37", i, vc); end
      total++; if (vd !== pv[i]) begin bad++; $display("FAIL single_data scan%0d got=%h exp=%h", i, vd, pv[i]); end
      total++; if (we !== 0) begin bad++; $display("FAIL single_wave scan%0d errors=%0d first_cycle=%0d exp=0", i, we, fb); end
      total++; if (ri !== 8) begin bad++; $display("FAIL single_rises scan%0d got=%0d exp=8", i, ri); end
      total++; if (nv !== 1) begin bad++; $display("FAIL single_nvalid scan%0d got=%0d exp=1", i, nv); end
      repeat (5) @(negedge clk);
      total++; if (dout[0] !== pv[i]) begin bad++; $display("FAIL single_hold scan%0d got=%h exp=%h", i, dout[0], pv[i]); end
    end
  endtask

  task automatic test_reset_midscan();
    int nvalid;
    int nbusy;
    par[0] = 16'($urandom) & 16'h00FF;
    @(negedge clk);
    start[0] = 1'b1;
    nvalid = 0;
    nbusy  = 0;
    for (int j = 1; j <= 70; j++) begin
      @(negedge clk);
      start[0] = 1'b0;
      if (j == 9) rst = 1'b1;
      if (j == 12) rst = 1'b0;
      if (j >= 10) begin
        if (valid[0] === 1'b1) nvalid++;
        if (busy[0] === 1'b1) nbusy++;
      end
      if (j >= 10 && j <= 12) begin
        total++;
        if (shld[0] !== 1'b1 || sclk[0] !== 1'b0 || busy[0] !== 1'b0 || dout[0] !== 16'h00FF) begin
          bad++;
          $display("FAIL midreset_outputs cycle%0d got shld=%b sclk=%b busy=%b data=%h exp 1 0 0 00ff",
                   j, shld[0], sclk[0], busy[0], dout[0]);
        end
      end
    end
    total++; if (nvalid !== 0) begin bad++; $display("FAIL midreset_novalid got=%0d exp=0", nvalid); end
    total++; if (nbusy !== 0) begin bad++; $display("FAIL midreset_nobusy got=%0d exp=0", nbusy); end
    total++; if (dout[0] !== 16'h00FF) begin bad++; $display("FAIL midreset_data got=%h exp=00ff", dout[0]); end
  endtask

  task automatic test_chain();
    logic [15:0] pv [3];
    int vc, we, fb, ri, nv;
    logic [15:0] vd;
    pv[0] = 16'h48A0;
    pv[1] = 16'($urandom);
    pv[2] = 16'($urandom);
    for (int i = 0; i < 3; i++) begin
      do_scan(1, pv[i], 0, 0, vc, vd, we, fb, ri, nv);
      total++; if (vc !== 35) begin bad++; $display("FAIL chain_latency scan%0d got=%0d exp=35", i, vc); end
      total++; if (vd !== pv[i]) begin bad++; $display("FAIL chain_data scan%0d got=%h exp=%h", i, vd, pv[i]); end
      total++; if (we !== 0) begin bad++; $display("FAIL chain_wave scan%0d errors=%0d first_cycle=%0d exp=0", i, we, fb); end
      total++; if (ri !== 16) begin bad++; $display("FAIL chain_rises scan%0d got=%0d exp=16", i, ri); end
    end
  endtask

  task automatic test_busy_ignore();
    int vc, we, fb, ri, nv;
    logic [15:0] vd;
    logic [15:0] pv;
    pv = 16'($urandom) & 16'h00FF;
    do_scan(0, pv, 1, 0, vc, vd, we, fb, ri, nv);
    total++; if (nv !== 1) begin bad++; $display("FAIL busy_nvalid got=%0d exp=1", nv); end
    total++; if (vd !== pv) begin bad++; $display("FAIL busy_data got=%h exp=%h", vd, pv); end
    total++; if (we !== 0) begin bad++; $display("FAIL busy_wave errors=%0d first_cycle=%0d exp=0", we, fb); end
    total++; if (vc !== 37) begin bad++; $display("FAIL busy_latency got=%0d exp=37", vc); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] vals [4];
    int lat;
    int period;
    int nseen;
    int nvalid;
    lat    = lat_of(2);
    period = lat + 1;
    vals[0] = 16'h0000;
    vals[1] = 16'h00FF;
    vals[2] = 16'($urandom) & 16'h00FF;
    vals[3] = 16'($urandom) & 16'h00FF;
    par[2] = vals[0];
    nseen  = 0;
    nvalid = 0;
    @(negedge clk);
    start[2] = 1'b1;
    for (int j = 1; j <= 4 * period + 8; j++) begin
      @(negedge clk);
      if (valid[2] === 1'b1) begin
        nvalid++;
        if (nseen < 4) begin
          total++;
          if (j !== lat + nseen * period) begin
            bad++; $display("FAIL b2b_time scan%0d got=%0d exp=%0d", nseen, j, lat + nseen * period);
          end
          total++;
          if (dout[2] !== vals[nseen]) begin
            bad++; $display("FAIL b2b_data scan%0d got=%h exp=%h", nseen, dout[2], vals[nseen]);
          end
          nseen++;
          if (nseen < 4) par[2] = vals[nseen];
          else start[2] = 1'b0;
        end
      end
    end
    start[2] = 1'b0;
    total++; if (nvalid !== 4) begin bad++; $display("FAIL b2b_count got=%0d exp=4", nvalid); end
  endtask

  task automatic test_timing();
    int vc, we, fb, ri, nv;
    logic [15:0] vd;
    logic [15:0] pv;
    logic [15:0] exp_d;
    int offs [3];
    pv = 16'($urandom) & 16'h00FF;
    do_scan(3, pv, 0, 0, vc, vd, we, fb, ri, nv);
    total++; if (we !== 0) begin bad++; $display("FAIL timing_wave errors=%0d first_cycle=%0d exp=0", we, fb); end
    total++; if (vc !== 55) begin bad++; $display("FAIL timing_latency got=%0d exp=55", vc); end
    total++; if (vd !== pv) begin bad++; $display("FAIL timing_data got=%h exp=%h", vd, pv); end
    total++; if (ri !== 8) begin bad++; $display("FAIL timing_rises got=%0d exp=8", ri); end
    offs[0] = 0;
    offs[1] = -1;
    offs[2] = 1;
    for (int i = 0; i < 3; i++) begin
      pv = 16'($urandom) & 16'h00FF;
      exp_d = (offs[i] == 0) ? pv : (~pv & 16'h00FF);
      do_scan(3, pv, 2, offs[i], vc, vd, we, fb, ri, nv);
      total++;
      if (vd !== exp_d) begin
        bad++; $display("FAIL sample_window off=%0d got=%h exp=%h", offs[i], vd, exp_d);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int g = 0; g < 4; g++) begin
      start[g] = 1'b0;
      qmode[g] = 1'b0;
      qman[g]  = 1'b0;
      par[g]   = '0;
    end
    test_reset();
    test_single();
    test_reset_midscan();
    test_chain();
    test_busy_ignore();
    test_back_to_back();
    test_timing();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
